// File: rtl/syncfifo_shared_pkg.sv
// Shared types and helpers for the multi-queue shared-buffer FIFO family.
//   QID_W      : width of a queue tag
//   SLOT_W     : width of a slot index at the largest supported pool (32 slots)
//   awid(d)    : address width needed to index d slots
package syncfifo_shared_pkg;

    localparam int unsigned QID_W     = 3;
    localparam int unsigned MAX_DEPTH = 32;
    localparam int unsigned SLOT_W    = 5;

    typedef logic [QID_W-1:0]  qid_t;
    typedef logic [SLOT_W-1:0] slot_idx_t;

    function automatic int unsigned awid(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/find_first_zero.sv
// Lowest-index zero bit of a vector.
//   vec     : input bit vector
//   idx_c   : index of the lowest zero bit (0 when none)
//   found_c : at least one zero bit exists
module find_first_zero #(
    parameter int unsigned W  = 8,
    parameter int unsigned IW = 3
) (
    input  logic [W-1:0]  vec,
    output logic [IW-1:0] idx_c,
    output logic          found_c
);

    always_comb begin
        idx_c   = '0;
        found_c = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            if (!found_c && !vec[i]) begin
                idx_c   = IW'(i);
                found_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb_grant.sv
// Round-robin grant over NQ requesters, optional strict priority for requester 0.
//   req         : request vector
//   last_grant  : most recent round-robin winner; search starts just after it
//   prio0_en    : requester 0 wins whenever it requests
//   grant_c     : winning index
//   grant_vld_c : some requester won
module rr_arb_grant
    import syncfifo_shared_pkg::*;
#(
    parameter int unsigned NQ = 5
) (
    input  logic [NQ-1:0] req,
    input  qid_t          last_grant,
    input  logic          prio0_en,
    output qid_t          grant_c,
    output logic          grant_vld_c
);

    int unsigned lg;
    int unsigned d;
    int unsigned best_d;

    // Pick the requester at the smallest rotational distance past last_grant.
    always_comb begin
        grant_c     = '0;
        grant_vld_c = 1'b0;
        lg          = 32'(last_grant);
        d           = 0;
        best_d      = NQ;
        for (int unsigned q = 0; q < NQ; q++) begin
            d = (q + NQ - 1 - lg) % NQ;
            if (req[q] && d < best_d) begin
                best_d      = d;
                grant_c     = QID_W'(q);
                grant_vld_c = 1'b1;
            end
        end
        if (prio0_en && req[0]) begin
            grant_c     = '0;
            grant_vld_c = 1'b1;
        end
    end

endmodule

// File: rtl/syncfifo.sv
// Small synchronous first-word-fall-through FIFO, used here to hold slot pointers.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear
//   push, din  : write request and data (ignored when full)
//   pop        : read request (ignored when empty)
//   dout_c     : head entry
//   empty_c    : no entries held
module syncfifo
    import syncfifo_shared_pkg::*;
#(
    parameter int unsigned AWID  = 3,
    parameter int unsigned DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            push,
    input  logic [AWID-1:0] din,
    input  logic            pop,
    output logic [AWID-1:0] dout_c,
    output logic            empty_c
);

    localparam int unsigned PW    = awid(DEPTH);
    localparam int unsigned CNT_W = PW + 1;

    logic [AWID-1:0]  mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign empty_c = (cnt == '0);
    assign dout_c  = mem[rd_ptr];
    assign do_push = push && (cnt != CNT_W'(DEPTH));
    assign do_pop  = pop && !empty_c;

    // Storage carries no reset; validity is tracked by cnt.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/syncfifo_shared_merge.sv
// Multi-queue shared-buffer FIFO with a merged, round-robin arbitrated output.
// Writes carry a queue tag and land in the lowest free pool slot; each queue keeps
// a FIFO of slot pointers. One registered output port drains all queues.
// Optional macro SYNCFIFO_SHARED_MERGE_PRIO0_EN: queue 0 gets strict priority.
//   clk, rst_n     : clock, async active-low reset
//   softreset      : synchronous clear of all state, wins over write/read
//   vldin, qid, din: write request, destination queue, data
//   full           : every pool slot occupied
//   vldout, dout, qout : output register valid, data, source queue
//   readout        : consume the output entry
//   qempty         : per-queue pointer FIFO empty
//   count          : occupied pool slots plus output register
module syncfifo_shared_merge
    import syncfifo_shared_pkg::*;
#(
    parameter int unsigned WID   = 32,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned NQ    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             softreset,
    input  logic             vldin,
    input  logic [2:0]       qid,
    input  logic [WID-1:0]   din,
    output logic             full,
    output logic             vldout,
    output logic [WID-1:0]   dout,
    output logic [2:0]       qout,
    input  logic             readout,
    output logic [NQ-1:0]    qempty,
    output logic [15:0]      count
);

    localparam int unsigned AWID = awid(DEPTH);

`ifdef SYNCFIFO_SHARED_MERGE_PRIO0_EN
    localparam logic PRIO0 = 1'b1;
`else
    localparam logic PRIO0 = 1'b0;
`endif

    logic [DEPTH-1:0] occupied;
    logic [DEPTH-1:0] occ_next;
    logic [WID-1:0]   bufs [DEPTH];
    qid_t             last_grant;

    logic [AWID-1:0]  free_slot;
    logic             free_found;
    logic [AWID-1:0]  q_head [NQ];
    logic [NQ-1:0]    q_push;
    logic [NQ-1:0]    q_pop;
    logic [AWID-1:0]  head_ptr;
    qid_t             grant;
    logic             grant_vld;
    logic             wr_ok;
    logic             load;

    find_first_zero #(
        .W  (DEPTH),
        .IW (AWID)
    ) u_ffz (
        .vec     (occupied),
        .idx_c   (free_slot),
        .found_c (free_found)
    );

    assign full  = !free_found;
    assign wr_ok = vldin && !full && (32'(qid) < NQ);

    rr_arb_grant #(
        .NQ (NQ)
    ) u_arb (
        .req         (~qempty),
        .last_grant  (last_grant),
        .prio0_en    (PRIO0),
        .grant_c     (grant),
        .grant_vld_c (grant_vld)
    );

    assign load = (!vldout || readout) && grant_vld;

    // One pointer FIFO per queue; a queue can own every pool slot.
    for (genvar q = 0; q < NQ; q++) begin : g_q
        assign q_push[q] = wr_ok && (qid == QID_W'(q));
        assign q_pop[q]  = load && (grant == QID_W'(q));

        syncfifo #(
            .AWID  (AWID),
            .DEPTH (DEPTH)
        ) u_ptr (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (softreset),
            .push    (q_push[q]),
            .din     (free_slot),
            .pop     (q_pop[q]),
            .dout_c  (q_head[q]),
            .empty_c (qempty[q])
        );
    end

    // Head pointer of the granted queue.
    always_comb begin
        head_ptr = '0;
        for (int unsigned q = 0; q < NQ; q++) begin
            if (grant == QID_W'(q)) begin
                head_ptr = q_head[q];
            end
        end
    end

    // The write slot is chosen from the pre-edge map, so it never aliases the slot being freed.
    always_comb begin
        occ_next = occupied;
        if (load) begin
            occ_next[head_ptr] = 1'b0;
        end
        if (wr_ok) begin
            occ_next[free_slot] = 1'b1;
        end
    end

    assign count = 16'($countones(occupied)) + 16'(vldout);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            bufs[free_slot] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupied   <= '0;
            vldout     <= 1'b0;
            dout       <= '0;
            qout       <= '0;
            last_grant <= QID_W'(NQ - 1);
        end else if (softreset) begin
            occupied   <= '0;
            vldout     <= 1'b0;
            dout       <= '0;
            qout       <= '0;
            last_grant <= QID_W'(NQ - 1);
        end else begin
            occupied <= occ_next;
            if (load) begin
                vldout <= 1'b1;
                dout   <= bufs[head_ptr];
                qout   <= grant;
                // A strict-priority queue-0 grant leaves the round-robin position alone.
                if (!PRIO0 || grant != '0) begin
                    last_grant <= grant;
                end
            end else if (readout) begin
                vldout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_syncfifo_shared_merge.sv
// Directed, table-driven bench for syncfifo_shared_merge (default parameters).
module tb_syncfifo_shared_merge;

    localparam int unsigned WID   = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned NQ    = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            softreset;
    logic            vldin;
    logic [2:0]      qid;
    logic [WID-1:0]  din;
    logic            full;
    logic            vldout;
    logic [WID-1:0]  dout;
    logic [2:0]      qout;
    logic            readout;
    logic [NQ-1:0]   qempty;
    logic [15:0]     count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    syncfifo_shared_merge #(
        .WID   (WID),
        .DEPTH (DEPTH),
        .NQ    (NQ)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .softreset (softreset),
        .vldin     (vldin),
        .qid       (qid),
        .din       (din),
        .full      (full),
        .vldout    (vldout),
        .dout      (dout),
        .qout      (qout),
        .readout   (readout),
        .qempty    (qempty),
        .count     (count)
    );

    typedef struct {
        logic        vldin;
        logic [2:0]  qid;
        logic [31:0] din;
        logic        readout;
        logic        e_vld;
        logic [31:0] e_dout;
        logic [2:0]  e_qout;
        logic [15:0] e_count;
        logic        e_full;
        logic [4:0]  e_qempty;
    } vec_t;

    vec_t vecs [19];

    function automatic vec_t mk(input logic v, input logic [2:0] q, input logic [31:0] d,
                                input logic r, input logic ev, input logic [31:0] ed,
                                input logic [2:0] eq, input logic [15:0] ec, input logic ef,
                                input logic [4:0] ee);
        vec_t t;
        t.vldin = v;  t.qid = q;  t.din = d;  t.readout = r;
        t.e_vld = ev; t.e_dout = ed; t.e_qout = eq; t.e_count = ec;
        t.e_full = ef; t.e_qempty = ee;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Full output check; dout/qout only matter while vldout is expected high.
    task automatic chk_out(input string tag, input logic ev, input logic [31:0] ed,
                           input logic [2:0] eq, input logic [15:0] ec, input logic ef,
                           input logic [4:0] ee);
        chk({tag, ".vldout"}, 32'(vldout), 32'(ev));
        chk({tag, ".count"},  32'(count),  32'(ec));
        chk({tag, ".full"},   32'(full),   32'(ef));
        chk({tag, ".qempty"}, 32'(qempty), 32'(ee));
        if (ev) begin
            chk({tag, ".dout"}, dout,        ed);
            chk({tag, ".qout"}, 32'(qout),   32'(eq));
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] q, input logic [31:0] d, input logic r);
        vldin   = v;
        qid     = q;
        din     = d;
        readout = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //               vld qid din    rd | vld dout  q cnt full qempty
        vecs[0]  = mk(1, 2, 32'hA5, 1,  0, 0,     0, 1, 0, 5'h1b);
        vecs[1]  = mk(0, 0, 0,      1,  1, 32'hA5, 2, 1, 0, 5'h1f);
        vecs[2]  = mk(0, 0, 0,      1,  0, 0,     0, 0, 0, 5'h1f);
        vecs[3]  = mk(1, 4, 32'h40, 0,  0, 0,     0, 1, 0, 5'h0f);
        vecs[4]  = mk(1, 3, 32'h30, 0,  1, 32'h40, 4, 2, 0, 5'h17);
        vecs[5]  = mk(1, 0, 32'h10, 0,  1, 32'h40, 4, 3, 0, 5'h16);
        vecs[6]  = mk(1, 1, 32'h11, 0,  1, 32'h40, 4, 4, 0, 5'h14);
        vecs[7]  = mk(0, 0, 0,      1,  1, 32'h10, 0, 3, 0, 5'h15);
        vecs[8]  = mk(0, 0, 0,      1,  1, 32'h11, 1, 2, 0, 5'h17);
        vecs[9]  = mk(0, 0, 0,      1,  1, 32'h30, 3, 1, 0, 5'h1f);
        vecs[10] = mk(0, 0, 0,      1,  0, 0,     0, 0, 0, 5'h1f);
        vecs[11] = mk(1, 1, 32'h21, 0,  0, 0,     0, 1, 0, 5'h1d);
        vecs[12] = mk(1, 0, 32'h20, 0,  1, 32'h21, 1, 2, 0, 5'h1e);
        vecs[13] = mk(1, 4, 32'h24, 0,  1, 32'h21, 1, 3, 0, 5'h0e);
`ifdef SYNCFIFO_SHARED_MERGE_PRIO0_EN
        vecs[14] = mk(0, 0, 0,      1,  1, 32'h20, 0, 2, 0, 5'h0f);
        vecs[15] = mk(0, 0, 0,      1,  1, 32'h24, 4, 1, 0, 5'h1f);
`else
        vecs[14] = mk(0, 0, 0,      1,  1, 32'h24, 4, 2, 0, 5'h1e);
        vecs[15] = mk(0, 0, 0,      1,  1, 32'h20, 0, 1, 0, 5'h1f);
`endif
        vecs[16] = mk(0, 0, 0,      1,  0, 0,     0, 0, 0, 5'h1f);
        vecs[17] = mk(1, 5, 32'h55, 0,  0, 0,     0, 0, 0, 5'h1f);
        vecs[18] = mk(1, 7, 32'h77, 0,  0, 0,     0, 0, 0, 5'h1f);

        // Reset state, then idle after release.
        rst_n     = 1'b0;
        softreset = 1'b0;
        drive(0, 0, 0, 0);
        #12;
        chk_out("rst", 0, 0, 0, 0, 0, 5'h1f);
        chk("rst.dout", dout, 32'h0);
        chk("rst.qout", 32'(qout), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        chk_out("idle", 0, 0, 0, 0, 0, 5'h1f);

        // Latency, arbitration order and illegal queue tags.
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].vldin, vecs[i].qid, vecs[i].din, vecs[i].readout);
            step();
            chk_out($sformatf("row%0d", i), vecs[i].e_vld, vecs[i].e_dout, vecs[i].e_qout,
                    vecs[i].e_count, vecs[i].e_full, vecs[i].e_qempty);
        end

        // Fill: 10 writes to q1 with output stalled; capacity is DEPTH+1.
        for (int i = 1; i <= 10; i++) begin
            drive(1, 1, 32'(i), 0);
            step();
            chk($sformatf("fill%0d.count", i), 32'(count), 32'((i > 9) ? 9 : i));
            chk($sformatf("fill%0d.full", i), 32'(full), 32'(i >= 9));
        end
        chk_out("fill_end", 1, 32'd1, 1, 9, 1, 5'h1d);

        // Write while full plus read: write dropped, slot freed but not reused.
        drive(1, 1, 32'h99, 1);
        step();
        chk_out("full_rw", 1, 32'd2, 1, 8, 0, 5'h1d);
        drive(1, 1, 32'h9A, 0);
        step();
        chk_out("refill", 1, 32'd2, 1, 9, 1, 5'h1d);

        // Drain with readout held high: one entry per cycle, no gaps.
        for (int k = 3; k <= 10; k++) begin
            drive(0, 0, 0, 1);
            step();
            chk($sformatf("drain%0d.vldout", k), 32'(vldout), 32'h1);
            chk($sformatf("drain%0d.dout", k), dout, (k == 10) ? 32'h9A : 32'(k));
        end
        step();
        chk_out("drained", 0, 0, 0, 0, 0, 5'h1f);

        // softreset mid-drain, winning over a same-cycle write and read.
        for (int q = 0; q < 5; q++) begin
            drive(1, 3'(q), 32'h60 + 32'(q), 0);
            step();
        end
        chk("pre_sr.count", 32'(count), 32'd5);
        drive(0, 0, 0, 1);
        step();
        chk("mid_drain.count", 32'(count), 32'd4);
        softreset = 1'b1;
        drive(1, 0, 32'hEE, 1);
        step();
        softreset = 1'b0;
        chk_out("softreset", 0, 0, 0, 0, 0, 5'h1f);
        drive(1, 0, 32'h77, 0);
        step();
        chk_out("post_sr1", 0, 0, 0, 1, 0, 5'h1e);
        drive(0, 0, 0, 0);
        step();
        chk_out("post_sr2", 1, 32'h77, 0, 1, 0, 5'h1f);

        // Asynchronous reset takes effect without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 0, 0, 0, 0, 0, 5'h1f);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
